// File: rtl/ms_dbg_uart_rx_framer.sv
// ============================================================================
// ms_dbg_uart_rx_framer: 8N1 UART receiver feeding a header/payload framer.
// Rev 1.0
// ============================================================================
`default_nettype none

module ms_dbg_uart_rx_framer #(
    parameter logic [15:0] CBaudDiv = 16'd8,
    parameter logic [7:0]  CGapTmo  = 8'd20
) (
    input  logic        AClkH,
    input  logic        AResetH,
    input  logic        AClkHEn,
    input  logic        ASync1K,
    input  logic        ADbgRx,
    input  logic        ADbioIdxReset,
    output logic [11:0] ADbioAddr,
    output logic [63:0] ADbioMosi,
    output logic        ADbioMosiStb,
    output logic [3:0]  ADbioMosiIdx,
    output logic        ADbioMosi1st,
    output logic [15:0] ADbioDataLen,
    output logic        ADbioDataLenNZ,
    output logic        AFrameDone,
    output logic        AFrameErr,
    output logic [7:0]  AErrCnt
);

    typedef enum logic [2:0] {BIdle, BStart, BData, BStop, BWaitHi} bit_st_t;
    typedef enum logic [2:0] {SHdrAL, SHdrAH, SLenL, SLenH, SData} frm_st_t;

    localparam logic [15:0] CHalf = CBaudDiv >> 1;

    logic        rx_s1_q, rx_s2_q;
    bit_st_t     bst_q, bst_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        byte_vld, ferr;

    frm_st_t     fst_q, fst_d;
    logic [7:0]  addr_lo_q, addr_lo_d, len_lo_q, len_lo_d, gap_q, gap_d, errcnt_q, errcnt_d;
    logic [11:0] addr_q, addr_d;
    logic [15:0] dlen_q, dlen_d;
    logic [63:0] word_q, word_d, mosi_q, mosi_d, merged;
    logic [2:0]  lane_q, lane_d;
    logic [3:0]  nidx_q, nidx_d, oidx_q, oidx_d;
    logic        nfirst_q, nfirst_d, ofirst_q, ofirst_d;
    logic        stb_q, stb_d, done_q, done_d, err_q, err_d, tmo;

    // Bit-level receiver: mid-bit sampling timed from the synchronised falling edge.
    always_comb begin
        bst_d    = bst_q;
        bcnt_d   = bcnt_q;
        bidx_d   = bidx_q;
        shreg_d  = shreg_q;
        byte_vld = 1'b0;
        ferr     = 1'b0;
        if (AClkHEn) begin
            case (bst_q)
                BIdle: if (!rx_s2_q) begin
                    bst_d  = BStart;
                    bcnt_d = 16'd0;
                end
                BStart: if (bcnt_q == CHalf - 16'd1) begin
                    bcnt_d = 16'd0;
                    bidx_d = 3'd0;
                    bst_d  = rx_s2_q ? BIdle : BData;
                end else begin
                    bcnt_d = bcnt_q + 16'd1;
                end
                BData: if (bcnt_q == CBaudDiv - 16'd1) begin
                    bcnt_d  = 16'd0;
                    shreg_d = {rx_s2_q, shreg_q[7:1]};
                    if (bidx_q == 3'd7) bst_d = BStop;
                    else                bidx_d = bidx_q + 3'd1;
                end else begin
                    bcnt_d = bcnt_q + 16'd1;
                end
                BStop: if (bcnt_q == CBaudDiv - 16'd1) begin
                    bcnt_d = 16'd0;
                    if (rx_s2_q) begin
                        byte_vld = 1'b1;
                        bst_d    = BIdle;
                    end else begin
                        ferr  = 1'b1;
                        bst_d = BWaitHi;
                    end
                end else begin
                    bcnt_d = bcnt_q + 16'd1;
                end
                BWaitHi: if (rx_s2_q) bst_d = BIdle;
                default: bst_d = BIdle;
            endcase
        end
    end

    assign merged = word_q | (64'(shreg_q) << {lane_q, 3'b000});
    assign tmo    = (fst_q != SHdrAL) && !byte_vld && ASync1K &&
                    (CGapTmo != 8'd0) && (gap_q == CGapTmo - 8'd1);

    always_comb begin
        fst_d     = fst_q;
        addr_lo_d = addr_lo_q;
        len_lo_d  = len_lo_q;
        addr_d    = addr_q;
        dlen_d    = dlen_q;
        word_d    = word_q;
        lane_d    = lane_q;
        mosi_d    = mosi_q;
        nidx_d    = nidx_q;
        nfirst_d  = nfirst_q;
        oidx_d    = oidx_q;
        ofirst_d  = ofirst_q;
        gap_d     = gap_q;
        errcnt_d  = errcnt_q;
        stb_d     = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (AClkHEn) begin
            if (fst_q == SHdrAL || byte_vld) gap_d = 8'd0;
            else if (ASync1K)                gap_d = gap_q + 8'd1;
            if (byte_vld) begin
                case (fst_q)
                    SHdrAL: begin
                        addr_lo_d = shreg_q;
                        fst_d     = SHdrAH;
                    end
                    SHdrAH: begin
                        addr_d = {shreg_q[3:0], addr_lo_q};
                        fst_d  = SLenL;
                    end
                    SLenL: begin
                        len_lo_d = shreg_q;
                        fst_d    = SLenH;
                    end
                    SLenH: begin
                        dlen_d   = {shreg_q, len_lo_q};
                        nidx_d   = 4'd0;
                        nfirst_d = 1'b1;
                        word_d   = 64'd0;
                        lane_d   = 3'd0;
                        if ({shreg_q, len_lo_q} == 16'd0) begin
                            done_d = 1'b1;
                            fst_d  = SHdrAL;
                        end else begin
                            fst_d = SData;
                        end
                    end
                    SData: begin
                        dlen_d = dlen_q - 16'd1;
                        if (lane_q == 3'd7 || dlen_q == 16'd1) begin
                            mosi_d   = merged;
                            stb_d    = 1'b1;
                            oidx_d   = nidx_q;
                            ofirst_d = nfirst_q;
                            nidx_d   = nidx_q + 4'd1;
                            nfirst_d = 1'b0;
                            word_d   = 64'd0;
                            lane_d   = 3'd0;
                            if (dlen_q == 16'd1) begin
                                done_d = 1'b1;
                                fst_d  = SHdrAL;
                            end
                        end else begin
                            word_d = merged;
                            lane_d = lane_q + 3'd1;
                        end
                    end
                    default: fst_d = SHdrAL;
                endcase
            end
            if (ferr || tmo) begin
                fst_d  = SHdrAL;
                dlen_d = 16'd0;
                word_d = 64'd0;
                lane_d = 3'd0;
                gap_d  = 8'd0;
                err_d  = 1'b1;
                if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
            end
            // Applied after the emit so a coincident strobe keeps its old index.
            if (ADbioIdxReset) begin
                nidx_d   = 4'd0;
                nfirst_d = 1'b1;
            end
        end
    end

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            bst_q     <= BIdle;
            bcnt_q    <= 16'd0;
            bidx_q    <= 3'd0;
            shreg_q   <= 8'd0;
            fst_q     <= SHdrAL;
            addr_lo_q <= 8'd0;
            len_lo_q  <= 8'd0;
            addr_q    <= 12'd0;
            dlen_q    <= 16'd0;
            word_q    <= 64'd0;
            lane_q    <= 3'd0;
            mosi_q    <= 64'd0;
            nidx_q    <= 4'd0;
            nfirst_q  <= 1'b0;
            oidx_q    <= 4'd0;
            ofirst_q  <= 1'b0;
            gap_q     <= 8'd0;
            errcnt_q  <= 8'd0;
            stb_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (AClkHEn) begin
                rx_s1_q <= ADbgRx;
                rx_s2_q <= rx_s1_q;
            end
            bst_q     <= bst_d;
            bcnt_q    <= bcnt_d;
            bidx_q    <= bidx_d;
            shreg_q   <= shreg_d;
            fst_q     <= fst_d;
            addr_lo_q <= addr_lo_d;
            len_lo_q  <= len_lo_d;
            addr_q    <= addr_d;
            dlen_q    <= dlen_d;
            word_q    <= word_d;
            lane_q    <= lane_d;
            mosi_q    <= mosi_d;
            nidx_q    <= nidx_d;
            nfirst_q  <= nfirst_d;
            oidx_q    <= oidx_d;
            ofirst_q  <= ofirst_d;
            gap_q     <= gap_d;
            errcnt_q  <= errcnt_d;
            stb_q     <= stb_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ADbioAddr      = addr_q;
    assign ADbioMosi      = mosi_q;
    assign ADbioMosiStb   = stb_q;
    assign ADbioMosiIdx   = oidx_q;
    assign ADbioMosi1st   = ofirst_q;
    assign ADbioDataLen   = dlen_q;
    assign ADbioDataLenNZ = (dlen_q != 16'd0);
    assign AFrameDone     = done_q;
    assign AFrameErr      = err_q;
    assign AErrCnt        = errcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ms_dbg_uart_rx_framer.sv
// ============================================================================
// tb_ms_dbg_uart_rx_framer: randomized UART frames against a queue scoreboard.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ms_dbg_uart_rx_framer;

    localparam logic [15:0] BAUD = 16'd8;
    localparam logic [7:0]  GAP  = 8'd20;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b1, sync1k = 1'b0, rx = 1'b1, idxrst = 1'b0;
    logic [11:0] addr;
    logic [63:0] mosi;
    logic        stb, first, nz, done, err;
    logic [3:0]  idx;
    logic [15:0] dlen;
    logic [7:0]  errcnt;

    ms_dbg_uart_rx_framer #(.CBaudDiv(BAUD), .CGapTmo(GAP)) dut (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en), .ASync1K(sync1k), .ADbgRx(rx),
        .ADbioIdxReset(idxrst), .ADbioAddr(addr), .ADbioMosi(mosi), .ADbioMosiStb(stb),
        .ADbioMosiIdx(idx), .ADbioMosi1st(first), .ADbioDataLen(dlen),
        .ADbioDataLenNZ(nz), .AFrameDone(done), .AFrameErr(err), .AErrCnt(errcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 word, 1 done without word, 2 error
        logic [63:0] mosi;
        logic [3:0]  idx;
        logic        first;
        logic        done;
        logic [15:0] dlen;
        logic [11:0] addr;
        logic [7:0]  errcnt;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] data_q[$];
    logic [7:0] m_errcnt = 8'd0;
    int         checks = 0, failures = 0, tick_cnt = 0;
    bit         en_rand = 1'b0;

    always @(posedge clk) begin
        #1;
        en       = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
        tick_cnt = tick_cnt + 1;
        sync1k   = (tick_cnt % 32 == 0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (stb || done || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: stb=%0b done=%0b err=%0b required none", stb, done, err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("stb", 64'(stb), 64'(mon_e.kind == 0));
                chk("done", 64'(done), 64'(mon_e.done));
                chk("err", 64'(err), 64'(mon_e.kind == 2));
                chk("dlen", 64'(dlen), 64'(mon_e.dlen));
                chk("dlen_nz", 64'(nz), 64'(mon_e.dlen != 0));
                if (mon_e.kind == 0) begin
                    chk("mosi", mosi, mon_e.mosi);
                    chk("idx", 64'(idx), 64'(mon_e.idx));
                    chk("first", 64'(first), 64'(mon_e.first));
                end
                if (mon_e.kind != 2) chk("addr", 64'(addr), 64'(mon_e.addr));
                else                 chk("errcnt", 64'(errcnt), 64'(mon_e.errcnt));
            end
        end
    end

    task automatic wait_en(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            if (en) c++;
        end
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            wait_en(int'(BAUD));
        end
        rx = 1'b1;
        wait_en(int'($urandom_range(0, 12)));
    endtask

    task automatic send_hdr(input logic [11:0] a, input int len);
        logic [15:0] l16;
        logic [3:0]  junk;
        l16  = 16'(len);
        junk = 4'($urandom);
        send_byte(a[7:0], 1'b1);
        send_byte({junk, a[11:8]}, 1'b1);
        send_byte(l16[7:0], 1'b1);
        send_byte(l16[15:8], 1'b1);
    endtask

    task automatic fill_rand(input int n);
        data_q.delete();
        for (int k = 0; k < n; k++) data_q.push_back(8'($urandom));
    endtask

    task automatic push_err();
        ev_t e;
        m_errcnt = m_errcnt + 8'd1;
        e.kind = 2; e.mosi = 64'd0; e.idx = 4'd0; e.first = 1'b0; e.done = 1'b0;
        e.dlen = 16'd0; e.addr = 12'd0; e.errcnt = m_errcnt;
        exp_q.push_back(e);
    endtask

    // Expected words come from slicing the payload into 8-byte groups.
    task automatic send_frame(input logic [11:0] a, input int len, input int irst);
        ev_t e;
        int  nw, got;
        nw = (len + 7) / 8;
        if (len == 0) begin
            e.kind = 1; e.mosi = 64'd0; e.idx = 4'd0; e.first = 1'b0; e.done = 1'b1;
            e.dlen = 16'd0; e.addr = a; e.errcnt = 8'd0;
            exp_q.push_back(e);
        end
        for (int w = 0; w < nw; w++) begin
            e.kind = 0;
            e.mosi = 64'd0;
            for (int l = 0; l < 8; l++)
                if (w * 8 + l < len) e.mosi[8*l +: 8] = data_q[w*8+l];
            if (irst >= 0 && w > irst) begin
                e.idx   = 4'((w - irst - 1) % 16);
                e.first = (w == irst + 1);
            end else begin
                e.idx   = 4'(w % 16);
                e.first = (w == 0);
            end
            got      = ((w + 1) * 8 < len) ? (w + 1) * 8 : len;
            e.done   = (w == nw - 1);
            e.dlen   = 16'(len - got);
            e.addr   = a;
            e.errcnt = 8'd0;
            exp_q.push_back(e);
        end
        send_hdr(a, len);
        for (int k = 0; k < len; k++) begin
            send_byte(data_q[k], 1'b1);
            if (irst >= 0 && k == (irst + 1) * 8 - 1) begin
                idxrst = 1'b1;
                do @(posedge clk); while (!en);
                #1 idxrst = 1'b0;
            end
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_mosi", mosi, 64'd0);
        chk("rst_stb", 64'(stb), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_first", 64'(first), 64'd0);
        chk("rst_dlen", 64'(dlen), 64'd0);
        chk("rst_nz", 64'(nz), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_errcnt", 64'(errcnt), 64'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        data_q.delete();
        for (int k = 1; k <= 16; k++) data_q.push_back(8'(k));
        send_frame(12'h100, 16, -1);
        drain("drain_16B");

        data_q.delete();
        data_q.push_back(8'hAA); data_q.push_back(8'hBB); data_q.push_back(8'hCC);
        send_frame(12'($urandom), 3, -1);
        drain("drain_3B");

        en_rand = 1'b1;
        fill_rand(136);
        send_frame(12'($urandom), 136, -1);
        drain("drain_136B");

        send_frame(12'($urandom), 0, -1);
        drain("drain_len0");

        for (int r = 0; r < 5; r++) begin
            fill_rand(int'($urandom_range(1, 24)));
            send_frame(12'($urandom), data_q.size(), -1);
            drain("drain_rand");
        end

        push_err();
        send_hdr(12'($urandom), 8);
        send_byte(8'($urandom), 1'b1);
        drain("gap_timeout");
        fill_rand(11);
        send_frame(12'($urandom), 11, -1);
        drain("after_gap");

        push_err();
        send_hdr(12'($urandom), 8);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
        drain("stop_err");
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        fill_rand(9);
        send_frame(12'($urandom), 9, -1);
        drain("after_glitch");

        fill_rand(32);
        send_frame(12'($urandom), 32, 1);
        drain("idx_reset");

        fork
            send_byte(8'h5A, 1'b1);
            begin
                repeat (30) @(posedge clk);
                #3 rst = 1'b1;
                #1;
                chk("mid_rst_addr", 64'(addr), 64'd0);
                chk("mid_rst_mosi", mosi, 64'd0);
                chk("mid_rst_errcnt", 64'(errcnt), 64'd0);
                chk("mid_rst_dlen", 64'(dlen), 64'd0);
                chk("mid_rst_stb", 64'(stb), 64'd0);
            end
        join
        @(posedge clk);
        #1 rst = 1'b0;
        m_errcnt = 8'd0;
        repeat (5) @(posedge clk);
        #1;
        fill_rand(20);
        send_frame(12'($urandom), 20, -1);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
